ysyx_2022040010_axi_sram: RTL
=============================

# ysyx_2022040010_axi_sram

- AXI4 responder (slave) with an internal 64-bit-wide SRAM array.
- Terminates the read and write channels issued by the core's AXI read/write initiator; used as the main-memory model in simulation and as the on-chip scratch memory behind the crossbar.
- Independent read and write engines; INCR bursts of up to 256 beats; byte-strobed writes; ID echoed on the R and B channels.

## Interface
Parameters:
- DATA_WIDTH, 64, AXI data width; fixed at 64.
- ADDR_WIDTH, 64, AXI address width.
- ID_WIDTH, 4, AXI ID width.
- DEPTH, 4096, number of 64-bit words.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- axi_aw_valid_i / axi_aw_ready_o  in/out  1  AW handshake.
- axi_aw_addr_i  in  ADDR_WIDTH  write start address.
- axi_aw_id_i  in  ID_WIDTH  write ID.
- axi_aw_len_i  in  8  beats minus 1.
- axi_aw_size_i  in  3  bytes per beat, log2.
- axi_aw_burst_i  in  2  burst type; treated as INCR regardless of value.
- axi_w_valid_i / axi_w_ready_o  in/out  1  W handshake.
- axi_w_data_i  in  64  write data.
- axi_w_strb_i  in  8  byte enables.
- axi_w_last_i  in  1  last write beat.
- axi_b_valid_o / axi_b_ready_i  out/in  1  B handshake.
- axi_b_resp_o  out  2  write response.
- axi_b_id_o  out  ID_WIDTH  echoed AW ID.
- axi_ar_valid_i / axi_ar_ready_o  in/out  1  AR handshake.
- axi_ar_addr_i  in  ADDR_WIDTH  read start address.
- axi_ar_id_i  in  ID_WIDTH  read ID.
- axi_ar_len_i  in  8  beats minus 1.
- axi_ar_size_i  in  3  bytes per beat, log2.
- axi_r_valid_o / axi_r_ready_i  out/in  1  R handshake.
- axi_r_data_o  out  64  read data.
- axi_r_resp_o  out  2  read response.
- axi_r_last_o  out  1  last read beat.
- axi_r_id_o  out  ID_WIDTH  echoed AR ID.

## Operation
Addressing:
- Word index = ((addr − BASE_ADDR) >> 3) mod DEPTH.
- Beat address advances by (1 << size) after each beat.
- Data is always the full aligned 64-bit word. The initiator shifts narrow data itself.

Read FSM, states R_IDLE and R_DATA:
- R_IDLE: axi_ar_ready_o = 1. On AR handshake, capture address, len, size and ID; load the R data register from the start word; go to R_DATA.
- R_DATA: axi_ar_ready_o = 0, axi_r_valid_o = 1.
- axi_r_last_o = 1 when beat counter == captured len.
- On R handshake with last = 0: increment the counter and load the next word into the data register.
- On R handshake with last = 1: return to R_IDLE.

Write FSM, states W_IDLE, W_DATA and W_RESP:
- W_IDLE: axi_aw_ready_o = 1. On AW handshake, capture address, len, size and ID; go to W_DATA.
- W_DATA: axi_w_ready_o = 1. Each W handshake writes the bytes with strb = 1 to the current word and advances the address.
- W_DATA, on a handshake with axi_w_last_i = 1: go to W_RESP.
- W_RESP: axi_b_valid_o = 1 with the captured ID. On B handshake, return to W_IDLE.

Response codes:
- axi_b_resp_o = 2'b10 (SLVERR) if the number of accepted beats != len + 1; otherwise 2'b00 (OKAY).
- Beats beyond len + 1 are accepted but not written.

## Timing
- Reset (reset = 0) clears both FSMs to IDLE, all counters to 0, and all valid, last, data, resp and id outputs to 0.
- axi_ar_ready_o and axi_aw_ready_o read 1 in IDLE, including while reset = 0.
- Reset asserted mid-burst aborts the burst immediately. No B or R response is issued for it.
- Read latency: axi_r_valid_o rises the cycle after the AR handshake. Each further beat follows one cycle after the previous R handshake.
- Read back-pressure: while axi_r_ready_i = 0, R data and last are held stable.
- Read throughput: one beat per cycle with continuous ready.
- Read bursts: at least one idle cycle between bursts (ready is low during R_DATA).
- Write latency: axi_b_valid_o rises the cycle after the last-W handshake. One dead cycle in W_IDLE follows each B handshake.
- Same word read and written in the same cycle: the read returns the old data (read-before-write).
- Read and write engines never stall each other.
- Address wrap-around of the word index is silent, unless the macro below is defined.

## Configuration
- AXI_SRAM_RANGE_CHECK_EN defined: any beat address outside [BASE_ADDR, BASE_ADDR + DEPTH*8) returns 2'b11 (DECERR).
  - Reads: that beat's data is 0 and its resp is 2'b11.
  - Writes: that beat's write is suppressed, and b_resp = 2'b11, which takes priority over SLVERR.
- Macro undefined: no range check. The index wraps modulo DEPTH, and r_resp is always 2'b00.

## Test plan
- Write len = 1, addr 0x8000_0010, data {0x1111…, 0x2222…}, strb 0xFF; then read len = 1 at the same address -> R beats 0x1111… then 0x2222…, last on beat 2, resp OKAY, id echoed.
- Write strb 0x0F, data 0xAAAA_AAAA_BBBB_BBBB, over a word holding 0 -> read returns 0x0000_0000_BBBB_BBBB.
- Read len = 3 with r_ready toggling 1/0 -> exactly 4 beats, data stable while ready = 0, last only on beat 4.
- AW len = 1 with w_last on beat 1 -> b_resp = 2'b10. The single beat is written.
- With AXI_SRAM_RANGE_CHECK_EN, read at 0x7FFF_FFF8 -> r_data 0, r_resp 2'b11. Without the macro -> returns word DEPTH − 1.
- Reset pulled low during R_DATA beat 2 of 4 -> r_valid 0 immediately; the next AR is accepted with ar_ready = 1 after release.

Source files
------------

// File: rtl/ysyx_2022040010_axi_sram_if.sv
// AXI4 read/write channel bundle between a core initiator and ysyx_2022040010_axi_sram.
// Signal names keep the responder's point of view (_i driven by master, _o by slave).
interface ysyx_2022040010_axi_sram_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 4
);
   logic                    axi_aw_valid_i;
   logic                    axi_aw_ready_o;
   logic [ADDR_WIDTH-1:0]   axi_aw_addr_i;
   logic [ID_WIDTH-1:0]     axi_aw_id_i;
   logic [7:0]              axi_aw_len_i;
   logic [2:0]              axi_aw_size_i;
   logic [1:0]              axi_aw_burst_i;

   logic                    axi_w_valid_i;
   logic                    axi_w_ready_o;
   logic [DATA_WIDTH-1:0]   axi_w_data_i;
   logic [DATA_WIDTH/8-1:0] axi_w_strb_i;
   logic                    axi_w_last_i;

   logic                    axi_b_valid_o;
   logic                    axi_b_ready_i;
   logic [1:0]              axi_b_resp_o;
   logic [ID_WIDTH-1:0]     axi_b_id_o;

   logic                    axi_ar_valid_i;
   logic                    axi_ar_ready_o;
   logic [ADDR_WIDTH-1:0]   axi_ar_addr_i;
   logic [ID_WIDTH-1:0]     axi_ar_id_i;
   logic [7:0]              axi_ar_len_i;
   logic [2:0]              axi_ar_size_i;

   logic                    axi_r_valid_o;
   logic                    axi_r_ready_i;
   logic [DATA_WIDTH-1:0]   axi_r_data_o;
   logic [1:0]              axi_r_resp_o;
   logic                    axi_r_last_o;
   logic [ID_WIDTH-1:0]     axi_r_id_o;

   modport master (
      output axi_aw_valid_i, axi_aw_addr_i, axi_aw_id_i, axi_aw_len_i, axi_aw_size_i,
             axi_aw_burst_i, axi_w_valid_i, axi_w_data_i, axi_w_strb_i, axi_w_last_i,
             axi_b_ready_i, axi_ar_valid_i, axi_ar_addr_i, axi_ar_id_i, axi_ar_len_i,
             axi_ar_size_i, axi_r_ready_i,
      input  axi_aw_ready_o, axi_w_ready_o, axi_b_valid_o, axi_b_resp_o, axi_b_id_o,
             axi_ar_ready_o, axi_r_valid_o, axi_r_data_o, axi_r_resp_o, axi_r_last_o,
             axi_r_id_o
   );

   modport slave (
      input  axi_aw_valid_i, axi_aw_addr_i, axi_aw_id_i, axi_aw_len_i, axi_aw_size_i,
             axi_aw_burst_i, axi_w_valid_i, axi_w_data_i, axi_w_strb_i, axi_w_last_i,
             axi_b_ready_i, axi_ar_valid_i, axi_ar_addr_i, axi_ar_id_i, axi_ar_len_i,
             axi_ar_size_i, axi_r_ready_i,
      output axi_aw_ready_o, axi_w_ready_o, axi_b_valid_o, axi_b_resp_o, axi_b_id_o,
             axi_ar_ready_o, axi_r_valid_o, axi_r_data_o, axi_r_resp_o, axi_r_last_o,
             axi_r_id_o
   );
endinterface

// File: rtl/ysyx_2022040010_axi_sram.sv
// AXI4 responder over a 64-bit SRAM array with independent read and write burst engines.
// Define AXI_SRAM_RANGE_CHECK_EN to answer out-of-window beats with DECERR instead of wrapping.
module ysyx_2022040010_axi_sram #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DEPTH      = 4096,
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
   input logic                       clock,
   input logic                       reset,
   ysyx_2022040010_axi_sram_if.slave axi
);
   localparam int unsigned IdxW  = $clog2(DEPTH);
   localparam int unsigned StrbW = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] Span     = ADDR_WIDTH'(DEPTH * 8);

   typedef enum logic {RIdle, RData} r_state_e;
   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // ---------------------------------------------------------------- read engine
   r_state_e              r_state_q, r_state_d;
   logic [ADDR_WIDTH-1:0] r_addr_q;
   logic [7:0]            r_len_q, r_cnt_q;
   logic [2:0]            r_size_q;
   logic [ID_WIDTH-1:0]   r_id_q;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic [1:0]            r_resp_q;
   logic                  ar_ready, r_valid, r_last, ar_hs, r_hs;
   logic [ADDR_WIDTH-1:0] r_src, r_off, r_step;
   logic [IdxW-1:0]       r_idx;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [1:0]            rd_resp;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state_q <= RIdle;
      else        r_state_q <= r_state_d;
   end

   always_comb begin
      r_state_d = r_state_q;
      ar_ready  = 1'b0;
      r_valid   = 1'b0;
      case (r_state_q)
         RIdle: begin
            ar_ready = 1'b1;
            if (axi.axi_ar_valid_i) r_state_d = RData;
         end
         RData: begin
            r_valid = 1'b1;
            if (axi.axi_r_ready_i && r_last) r_state_d = RIdle;
         end
         default: r_state_d = RIdle;
      endcase
   end

   assign r_last = (r_state_q == RData) && (r_cnt_q == r_len_q);
   assign ar_hs  = ar_ready & axi.axi_ar_valid_i;
   assign r_hs   = r_valid & axi.axi_r_ready_i;

   // In idle the start word comes straight off AR; mid-burst from the running beat address.
   assign r_src  = (r_state_q == RIdle) ? axi.axi_ar_addr_i : r_addr_q;
   assign r_step = ADDR_WIDTH'(1) << ((r_state_q == RIdle) ? axi.axi_ar_size_i : r_size_q);
   assign r_off  = r_src - BaseAddr;
   assign r_idx  = r_off[IdxW+2:3];

`ifdef AXI_SRAM_RANGE_CHECK_EN
   logic r_oob;
   assign r_oob   = (r_off >= Span);
   assign rd_data = r_oob ? '0 : mem[r_idx];
   assign rd_resp = r_oob ? 2'b11 : 2'b00;
`else
   assign rd_data = mem[r_idx];
   assign rd_resp = 2'b00;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_addr_q <= '0;
         r_len_q  <= '0;
         r_cnt_q  <= '0;
         r_size_q <= '0;
         r_id_q   <= '0;
         r_data_q <= '0;
         r_resp_q <= '0;
      end else if (ar_hs) begin
         r_addr_q <= r_src + r_step;
         r_len_q  <= axi.axi_ar_len_i;
         r_cnt_q  <= '0;
         r_size_q <= axi.axi_ar_size_i;
         r_id_q   <= axi.axi_ar_id_i;
         r_data_q <= rd_data;
         r_resp_q <= rd_resp;
      end else if (r_hs && !r_last) begin
         r_addr_q <= r_src + r_step;
         r_cnt_q  <= r_cnt_q + 8'd1;
         r_data_q <= rd_data;
         r_resp_q <= rd_resp;
      end
   end

   // --------------------------------------------------------------- write engine
   w_state_e              w_state_q, w_state_d;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_off;
   logic [7:0]            w_len_q;
   logic [8:0]            w_cnt_q;
   logic [2:0]            w_size_q;
   logic [ID_WIDTH-1:0]   w_id_q;
   logic [1:0]            b_resp_q;
   logic                  w_err_q, w_err_next;
   logic                  aw_ready, w_ready, b_valid, aw_hs, w_hs, w_in_len, w_oob, mem_we;
   logic [IdxW-1:0]       w_idx;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) w_state_q <= WIdle;
      else        w_state_q <= w_state_d;
   end

   always_comb begin
      w_state_d = w_state_q;
      aw_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      case (w_state_q)
         WIdle: begin
            aw_ready = 1'b1;
            if (axi.axi_aw_valid_i) w_state_d = WData;
         end
         WData: begin
            w_ready = 1'b1;
            if (axi.axi_w_valid_i && axi.axi_w_last_i) w_state_d = WResp;
         end
         WResp: begin
            b_valid = 1'b1;
            if (axi.axi_b_ready_i) w_state_d = WIdle;
         end
         default: w_state_d = WIdle;
      endcase
   end

   assign aw_hs    = aw_ready & axi.axi_aw_valid_i;
   assign w_hs     = w_ready & axi.axi_w_valid_i;
   assign w_off    = w_addr_q - BaseAddr;
   assign w_idx    = w_off[IdxW+2:3];
   // Beats past len+1 are still accepted so the initiator can drain, but never written.
   assign w_in_len = (w_cnt_q <= {1'b0, w_len_q});

`ifdef AXI_SRAM_RANGE_CHECK_EN
   assign w_oob = (w_off >= Span);
`else
   assign w_oob = 1'b0;
`endif

   assign mem_we     = w_hs & w_in_len & ~w_oob;
   assign w_err_next = w_err_q | (w_in_len & w_oob);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         w_addr_q <= '0;
         w_len_q  <= '0;
         w_cnt_q  <= '0;
         w_size_q <= '0;
         w_id_q   <= '0;
         w_err_q  <= 1'b0;
         b_resp_q <= '0;
      end else if (aw_hs) begin
         w_addr_q <= axi.axi_aw_addr_i;
         w_len_q  <= axi.axi_aw_len_i;
         w_cnt_q  <= '0;
         w_size_q <= axi.axi_aw_size_i;
         w_id_q   <= axi.axi_aw_id_i;
         w_err_q  <= 1'b0;
      end else if (w_hs) begin
         w_addr_q <= w_addr_q + (ADDR_WIDTH'(1) << w_size_q);
         if (w_cnt_q != '1) w_cnt_q <= w_cnt_q + 9'd1;
         w_err_q  <= w_err_next;
         if (axi.axi_w_last_i) begin
            if (w_err_next)                     b_resp_q <= 2'b11;
            else if (w_cnt_q != {1'b0, w_len_q}) b_resp_q <= 2'b10;
            else                                 b_resp_q <= 2'b00;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < StrbW; b++) begin
            if (axi.axi_w_strb_i[b]) mem[w_idx][8*b +: 8] <= axi.axi_w_data_i[8*b +: 8];
         end
      end
   end

   // ------------------------------------------------------------------- outputs
   assign axi.axi_ar_ready_o = ar_ready;
   assign axi.axi_r_valid_o  = r_valid;
   assign axi.axi_r_data_o   = r_data_q;
   assign axi.axi_r_resp_o   = r_resp_q;
   assign axi.axi_r_last_o   = r_last;
   assign axi.axi_r_id_o     = r_id_q;
   assign axi.axi_aw_ready_o = aw_ready;
   assign axi.axi_w_ready_o  = w_ready;
   assign axi.axi_b_valid_o  = b_valid;
   assign axi.axi_b_resp_o   = b_resp_q;
   assign axi.axi_b_id_o     = w_id_q;

   logic unused_bits;
   assign unused_bits = ^{r_off[2:0], r_off[ADDR_WIDTH-1:IdxW+3],
                          w_off[2:0], w_off[ADDR_WIDTH-1:IdxW+3], axi.axi_aw_burst_i};
endmodule
